// File: rtl/axi_sim_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi_sim_mem
// Brief    : AXI4 slave memory model with programmable read latency and
//            DECERR/SLVERR responses, backed by an internal 16-byte word array.
// Revision : 1.0 - initial release
// ============================================================================
module axi_sim_mem #(
    parameter int                          AXI_ID_WIDTH   = 8,
    parameter int                          AXI_ADDR_WIDTH = 40,
    parameter int                          AXI_DATA_WIDTH = 128,
    parameter int                          MEM_WORDS_LOG2 = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR      = 40'h1C000000,
    parameter int                          READ_LATENCY   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ar_valid,
    output logic                          ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     ar_addr,
    input  logic [AXI_ID_WIDTH-1:0]       ar_id,
    input  logic [7:0]                    ar_len,
    input  logic [2:0]                    ar_size,
    input  logic [1:0]                    ar_burst,
    input  logic                          aw_valid,
    output logic                          aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     aw_addr,
    input  logic [AXI_ID_WIDTH-1:0]       aw_id,
    input  logic [7:0]                    aw_len,
    input  logic [2:0]                    aw_size,
    input  logic [1:0]                    aw_burst,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]     w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   w_strb,
    input  logic                          w_last,
    input  logic [AXI_ID_WIDTH-1:0]       w_id,
    output logic                          b_valid,
    input  logic                          b_ready,
    output logic [AXI_ID_WIDTH-1:0]       b_id,
    output logic [1:0]                    b_resp,
    output logic                          r_valid,
    input  logic                          r_ready,
    output logic [AXI_DATA_WIDTH-1:0]     r_data,
    output logic [AXI_ID_WIDTH-1:0]       r_id,
    output logic [1:0]                    r_resp,
    output logic                          r_last
);

    localparam int c_AW    = AXI_ADDR_WIDTH;
    localparam int c_DW    = AXI_DATA_WIDTH;
    localparam int c_SW    = AXI_DATA_WIDTH / 8;
    localparam int c_IW    = AXI_ID_WIDTH;
    localparam int c_WORDS = 1 << MEM_WORDS_LOG2;

    localparam logic [3:0] c_LAT_LOAD = (READ_LATENCY == 0) ? 4'd0 : 4'(READ_LATENCY - 1);

    localparam logic [1:0] c_R_IDLE = 2'd0;
    localparam logic [1:0] c_R_WAIT = 2'd1;
    localparam logic [1:0] c_R_DATA = 2'd2;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_DATA = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    // Next beat address; WRAP keeps the bits above the (len+1)*2^size window.
    function automatic logic [c_AW-1:0] f_next_addr(
        input logic [c_AW-1:0] a,
        input logic [2:0]      sz,
        input logic [7:0]      len,
        input logic [1:0]      burst
    );
        logic [c_AW-1:0] step;
        logic [c_AW-1:0] mask;
        step = c_AW'(1) << sz;
        mask = ((c_AW'(len) + c_AW'(1)) << sz) - c_AW'(1);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + step) & mask);
            default: return a + step;
        endcase
    endfunction

    logic [c_DW-1:0] r_mem [c_WORDS];

    // ------------------------------------------------------------------ read
    logic [1:0]                r_rd_state;
    logic [1:0]                w_rd_state_nxt;
    logic [c_IW-1:0]           r_rd_id;
    logic [c_AW-1:0]           r_rd_addr;
    logic [7:0]                r_rd_len;
    logic [2:0]                r_rd_size;
    logic [1:0]                r_rd_burst;
    logic [7:0]                r_rd_beat;
    logic [3:0]                r_rd_cnt;
    logic [c_DW-1:0]           r_rd_data;
    logic [1:0]                r_rd_resp;

    logic                      w_ar_hs;
    logic                      w_r_hs;
    logic                      w_rd_at_len;
    logic                      w_rd_load;
    logic [c_AW-1:0]           w_rd_next;
    logic [c_AW-1:0]           w_rd_load_addr;
    logic [c_AW-1:0]           w_rd_off;
    logic                      w_rd_in_range;
    logic [MEM_WORDS_LOG2-1:0] w_rd_idx;

    assign w_ar_hs     = ar_valid && ar_ready;
    assign w_r_hs      = r_valid && r_ready;
    assign w_rd_at_len = (r_rd_beat == r_rd_len);
    assign w_rd_next   = f_next_addr(r_rd_addr, r_rd_size, r_rd_len, r_rd_burst);

    // Data is fetched into r_rd_data one cycle ahead of being presented.
    assign w_rd_load = ((r_rd_state == c_R_IDLE) && ar_valid && (READ_LATENCY == 0))
                    || ((r_rd_state == c_R_WAIT) && (r_rd_cnt == 4'd0))
                    || (w_r_hs && !w_rd_at_len);

    always_comb begin
        w_rd_load_addr = w_rd_next;
        case (r_rd_state)
            c_R_IDLE: w_rd_load_addr = ar_addr;
            c_R_WAIT: w_rd_load_addr = r_rd_addr;
            default:  w_rd_load_addr = w_rd_next;
        endcase
    end

    assign w_rd_off      = w_rd_load_addr - BASE_ADDR;
    assign w_rd_in_range = (w_rd_load_addr >= BASE_ADDR)
                        && (w_rd_off[c_AW-1:MEM_WORDS_LOG2+4] == '0);
    assign w_rd_idx      = w_rd_off[MEM_WORDS_LOG2+3:4];

    always_ff @(posedge clk) begin
        if (reset) r_rd_state <= c_R_IDLE;
        else       r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            c_R_IDLE: if (ar_valid) w_rd_state_nxt = (READ_LATENCY == 0) ? c_R_DATA : c_R_WAIT;
            c_R_WAIT: if (r_rd_cnt == 4'd0) w_rd_state_nxt = c_R_DATA;
            c_R_DATA: if (w_r_hs && w_rd_at_len) w_rd_state_nxt = c_R_IDLE;
            default:  w_rd_state_nxt = c_R_IDLE;
        endcase
    end

    always_comb begin
        ar_ready = reset || (r_rd_state == c_R_IDLE);
        r_valid  = !reset && (r_rd_state == c_R_DATA);
        r_last   = !reset && (r_rd_state == c_R_DATA) && w_rd_at_len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_id    <= '0;
            r_rd_addr  <= '0;
            r_rd_len   <= '0;
            r_rd_size  <= '0;
            r_rd_burst <= '0;
            r_rd_beat  <= '0;
            r_rd_cnt   <= '0;
            r_rd_data  <= '0;
            r_rd_resp  <= c_RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_rd_id    <= ar_id;
                r_rd_addr  <= ar_addr;
                r_rd_len   <= ar_len;
                r_rd_size  <= ar_size;
                r_rd_burst <= ar_burst;
                r_rd_beat  <= '0;
                r_rd_cnt   <= c_LAT_LOAD;
            end else if ((r_rd_state == c_R_WAIT) && (r_rd_cnt != 4'd0)) begin
                r_rd_cnt <= r_rd_cnt - 4'd1;
            end
            if (w_r_hs && !w_rd_at_len) begin
                r_rd_addr <= w_rd_next;
                r_rd_beat <= r_rd_beat + 8'd1;
            end
            if (w_rd_load) begin
                r_rd_data <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
                r_rd_resp <= w_rd_in_range ? c_RESP_OKAY : c_RESP_DECERR;
            end
        end
    end

    assign r_data = r_rd_data;
    assign r_id   = r_rd_id;
    assign r_resp = r_rd_resp;

    // ----------------------------------------------------------------- write
    logic [1:0]                r_wr_state;
    logic [1:0]                w_wr_state_nxt;
    logic [c_IW-1:0]           r_wr_id;
    logic [c_AW-1:0]           r_wr_addr;
    logic [7:0]                r_wr_len;
    logic [2:0]                r_wr_size;
    logic [1:0]                r_wr_burst;
    logic [7:0]                r_wr_beat;
    logic                      r_wr_decerr;
    logic [1:0]                r_wr_bresp;

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_wr_at_len;
    logic                      w_w_term;
    logic                      w_wr_proto_err;
    logic                      w_wr_en;
    logic [c_AW-1:0]           w_wr_off;
    logic                      w_wr_in_range;
    logic [MEM_WORDS_LOG2-1:0] w_wr_idx;

    assign w_aw_hs        = aw_valid && aw_ready;
    assign w_w_hs         = w_valid && w_ready;
    assign w_wr_at_len    = (r_wr_beat == r_wr_len);
    assign w_w_term       = w_w_hs && (w_last || w_wr_at_len);
    assign w_wr_proto_err = (w_last != w_wr_at_len);
    assign w_wr_off       = r_wr_addr - BASE_ADDR;
    assign w_wr_in_range  = (r_wr_addr >= BASE_ADDR)
                         && (w_wr_off[c_AW-1:MEM_WORDS_LOG2+4] == '0);
    assign w_wr_idx       = w_wr_off[MEM_WORDS_LOG2+3:4];
    assign w_wr_en        = w_w_hs && w_wr_in_range;

    always_ff @(posedge clk) begin
        if (reset) r_wr_state <= c_W_IDLE;
        else       r_wr_state <= w_wr_state_nxt;
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            c_W_IDLE: if (aw_valid) w_wr_state_nxt = c_W_DATA;
            c_W_DATA: if (w_w_term) w_wr_state_nxt = c_W_RESP;
            c_W_RESP: if (b_ready)  w_wr_state_nxt = c_W_IDLE;
            default:  w_wr_state_nxt = c_W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready = reset || (r_wr_state == c_W_IDLE);
        w_ready  = !reset && (r_wr_state == c_W_DATA);
        b_valid  = !reset && (r_wr_state == c_W_RESP);
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_SW; b++) begin
                if (w_strb[b]) r_mem[w_wr_idx][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_id     <= '0;
            r_wr_addr   <= '0;
            r_wr_len    <= '0;
            r_wr_size   <= '0;
            r_wr_burst  <= '0;
            r_wr_beat   <= '0;
            r_wr_decerr <= 1'b0;
            r_wr_bresp  <= c_RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_wr_id     <= aw_id;
                r_wr_addr   <= aw_addr;
                r_wr_len    <= aw_len;
                r_wr_size   <= aw_size;
                r_wr_burst  <= aw_burst;
                r_wr_beat   <= '0;
                r_wr_decerr <= 1'b0;
            end
            if (w_w_hs) begin
                r_wr_addr   <= f_next_addr(r_wr_addr, r_wr_size, r_wr_len, r_wr_burst);
                r_wr_beat   <= r_wr_beat + 8'd1;
                r_wr_decerr <= r_wr_decerr || !w_wr_in_range;
                if (w_w_term) begin
                    if (r_wr_decerr || !w_wr_in_range) r_wr_bresp <= c_RESP_DECERR;
                    else if (w_wr_proto_err)           r_wr_bresp <= c_RESP_SLVERR;
                    else                               r_wr_bresp <= c_RESP_OKAY;
                end
            end
        end
    end

    assign b_id   = r_wr_id;
    assign b_resp = r_wr_bresp;

    logic w_unused;
    assign w_unused = ^{w_id, w_rd_off[3:0], w_wr_off[3:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_sim_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_sim_mem
// Brief    : Directed self-checking bench for axi_sim_mem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sim_mem;

    localparam logic [39:0] c_BASE = 40'h1C000000;
    localparam logic [1:0]  c_INCR = 2'b01;
    localparam logic [1:0]  c_WRAP = 2'b10;

    logic          clk = 1'b0;
    logic          reset;
    logic          ar_valid, ar_ready;
    logic [39:0]   ar_addr;
    logic [7:0]    ar_id, ar_len;
    logic [2:0]    ar_size;
    logic [1:0]    ar_burst;
    logic          aw_valid, aw_ready;
    logic [39:0]   aw_addr;
    logic [7:0]    aw_id, aw_len;
    logic [2:0]    aw_size;
    logic [1:0]    aw_burst;
    logic          w_valid, w_ready;
    logic [127:0]  w_data;
    logic [15:0]   w_strb;
    logic          w_last;
    logic [7:0]    w_id;
    logic          b_valid, b_ready;
    logic [7:0]    b_id;
    logic [1:0]    b_resp;
    logic          r_valid, r_ready;
    logic [127:0]  r_data;
    logic [7:0]    r_id;
    logic [1:0]    r_resp;
    logic          r_last;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [127:0]  rd_data [16];
    logic [1:0]    rd_resp [16];
    logic          rd_last [16];
    logic [7:0]    rd_id;
    int            rd_wait;
    logic [1:0]    bresp;
    logic [7:0]    bid;

    always #5 clk = ~clk;

    axi_sim_mem #(
        .AXI_ID_WIDTH   (8),
        .AXI_ADDR_WIDTH (40),
        .AXI_DATA_WIDTH (128),
        .MEM_WORDS_LOG2 (16),
        .BASE_ADDR      (c_BASE),
        .READ_LATENCY   (2)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .ar_valid (ar_valid), .ar_ready (ar_ready), .ar_addr (ar_addr), .ar_id (ar_id),
        .ar_len   (ar_len),   .ar_size  (ar_size),  .ar_burst (ar_burst),
        .aw_valid (aw_valid), .aw_ready (aw_ready), .aw_addr (aw_addr), .aw_id (aw_id),
        .aw_len   (aw_len),   .aw_size  (aw_size),  .aw_burst (aw_burst),
        .w_valid  (w_valid),  .w_ready  (w_ready),  .w_data  (w_data),  .w_strb (w_strb),
        .w_last   (w_last),   .w_id     (w_id),
        .b_valid  (b_valid),  .b_ready  (b_ready),  .b_id    (b_id),    .b_resp (b_resp),
        .r_valid  (r_valid),  .r_ready  (r_ready),  .r_data  (r_data),  .r_id   (r_id),
        .r_resp   (r_resp),   .r_last   (r_last)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    // All tasks start and end on a falling edge.
    task automatic aw_issue(input logic [39:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [7:0] id);
        int g = 0;
        aw_addr = a; aw_len = len; aw_size = 3'd4; aw_burst = burst; aw_id = id; aw_valid = 1'b1;
        while (!aw_ready && g < 50) begin @(negedge clk); g++; end
        check("aw_ready_seen", aw_ready, 1);
        @(negedge clk);
        aw_valid = 1'b0;
    endtask

    task automatic ar_issue(input logic [39:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [7:0] id);
        int g = 0;
        ar_addr = a; ar_len = len; ar_size = 3'd4; ar_burst = burst; ar_id = id; ar_valid = 1'b1;
        while (!ar_ready && g < 50) begin @(negedge clk); g++; end
        check("ar_ready_seen", ar_ready, 1);
        @(negedge clk);
        ar_valid = 1'b0;
    endtask

    task automatic w_beat(input logic [127:0] d, input logic [15:0] s, input logic l);
        int g = 0;
        w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
        while (!w_ready && g < 50) begin @(negedge clk); g++; end
        check("w_ready_seen", w_ready, 1);
        @(negedge clk);
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic b_collect(output logic [1:0] resp, output logic [7:0] id);
        int g = 0;
        b_ready = 1'b1;
        while (!b_valid && g < 50) begin @(negedge clk); g++; end
        check("b_valid_seen", b_valid, 1);
        resp = b_resp; id = b_id;
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic write_incr(input logic [39:0] a, input logic [7:0] len, input logic [7:0] id,
                              input logic [7:0] b0, input logic [7:0] step);
        aw_issue(a, len, c_INCR, id);
        for (int i = 0; i <= int'(len); i++)
            w_beat(rep(b0 + 8'(i) * step), 16'hFFFF, (i == int'(len)));
        b_collect(bresp, bid);
    endtask

    task automatic r_collect(input int n, input bit toggle);
        int           beats = 0, waits = 0, guard = 0;
        bit           seen = 0, stalled = 0, ph = 0, rdy;
        logic [127:0] held = '0;
        rd_wait = -1;
        while (beats < n && guard < 200) begin
            if (r_valid) begin
                if (!seen) begin rd_wait = waits; seen = 1; rd_id = r_id; end
                if (stalled) check("r_data_stable", r_data, held);
                rdy = toggle ? ph : 1'b1;
                ph  = !ph;
                r_ready = rdy;
                if (rdy) begin
                    rd_data[beats] = r_data; rd_resp[beats] = r_resp; rd_last[beats] = r_last;
                    beats++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = r_data;
                end
            end else begin
                r_ready = 1'b0;
                if (!seen) waits++;
            end
            @(negedge clk);
            guard++;
        end
        r_ready = 1'b0;
        check("r_beats_seen", 128'(beats), 128'(n));
    endtask

    initial begin
        int g;
        reset = 1'b1;
        ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; w_id = 8'hA5;
        b_ready = 0; r_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_ctrl_during", {ar_ready, aw_ready, w_ready, r_valid, b_valid, r_last}, 6'b110000);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ctrl_after", {ar_ready, aw_ready, w_ready, r_valid, b_valid, r_last}, 6'b110000);
        check("rst_r_data", r_data, '0);
        check("rst_ids_resps", {r_id, r_resp, b_id, b_resp}, '0);

        // Write then read back an INCR burst
        write_incr(c_BASE, 8'd3, 8'h5A, 8'h11, 8'h11);
        check("wr1_bresp", bresp, 2'b00);
        check("wr1_bid", bid, 8'h5A);
        ar_issue(c_BASE, 8'd3, c_INCR, 8'h3C);
        r_collect(4, 0);
        check("rd1_latency", 128'(rd_wait), 128'(2));
        check("rd1_id", rd_id, 8'h3C);
        check("rd1_beat0", rd_data[0], rep(8'h11));
        check("rd1_beat1", rd_data[1], rep(8'h22));
        check("rd1_beat2", rd_data[2], rep(8'h33));
        check("rd1_beat3", rd_data[3], rep(8'h44));
        check("rd1_last", {rd_last[3], rd_last[2], rd_last[1], rd_last[0]}, 4'b1000);
        check("rd1_resp", {rd_resp[3], rd_resp[2], rd_resp[1], rd_resp[0]}, 8'h00);
        check("rd1_idle_after", {r_valid, ar_ready}, 2'b01);

        // Partial byte strobe
        write_incr(c_BASE + 40'h10, 8'd0, 8'h01, 8'hAA, 8'h00);
        aw_issue(c_BASE + 40'h10, 8'd0, c_INCR, 8'h02);
        w_beat(rep(8'h55), 16'h000F, 1'b1);
        b_collect(bresp, bid);
        check("strb_bresp", bresp, 2'b00);
        ar_issue(c_BASE + 40'h10, 8'd0, c_INCR, 8'h03);
        r_collect(1, 0);
        check("strb_data", rd_data[0], {{12{8'hAA}}, {4{8'h55}}});

        // WRAP read with r_ready toggling
        ar_issue(c_BASE + 40'h30, 8'd3, c_WRAP, 8'h04);
        r_collect(4, 1);
        check("wrap_beat0", rd_data[0], rep(8'h44));
        check("wrap_beat1", rd_data[1], rep(8'h11));
        check("wrap_beat2", rd_data[2], {{12{8'hAA}}, {4{8'h55}}});
        check("wrap_beat3", rd_data[3], rep(8'h33));
        check("wrap_last", {rd_last[3], rd_last[2], rd_last[1], rd_last[0]}, 4'b1000);

        // Out of range accesses and the top in-range word
        ar_issue(40'h1BFFFFF0, 8'd0, c_INCR, 8'h05);
        r_collect(1, 0);
        check("oor_rd_resp", rd_resp[0], 2'b11);
        check("oor_rd_data", rd_data[0], '0);
        check("oor_rd_last", rd_last[0], 1'b1);
        write_incr(c_BASE + 40'h100000, 8'd0, 8'h06, 8'hEE, 8'h00);
        check("oor_wr_bresp", bresp, 2'b11);
        ar_issue(c_BASE, 8'd0, c_INCR, 8'h07);
        r_collect(1, 0);
        check("oor_wr_no_alias", rd_data[0], rep(8'h11));
        ar_issue(40'h1C0FFFF0, 8'd0, c_INCR, 8'h08);
        r_collect(1, 0);
        check("top_word_resp", rd_resp[0], 2'b00);

        // Early w_last and missing w_last
        write_incr(c_BASE + 40'h80, 8'd3, 8'h09, 8'hC0, 8'h01);
        aw_issue(c_BASE + 40'h80, 8'd3, c_INCR, 8'h0A);
        w_beat(rep(8'h66), 16'hFFFF, 1'b0);
        w_beat(rep(8'h77), 16'hFFFF, 1'b1);
        check("early_last_state", {b_valid, aw_ready, w_ready}, 3'b100);
        b_collect(bresp, bid);
        check("early_last_bresp", bresp, 2'b10);
        check("early_last_aw_ready", aw_ready, 1'b1);
        ar_issue(c_BASE + 40'h80, 8'd3, c_INCR, 8'h0B);
        r_collect(4, 0);
        check("early_last_b0", rd_data[0], rep(8'h66));
        check("early_last_b1", rd_data[1], rep(8'h77));
        check("early_last_b2", rd_data[2], rep(8'hC2));
        check("early_last_b3", rd_data[3], rep(8'hC3));
        aw_issue(c_BASE + 40'h100, 8'd0, c_INCR, 8'h0C);
        w_beat(rep(8'h12), 16'hFFFF, 1'b0);
        b_collect(bresp, bid);
        check("missing_last_bresp", bresp, 2'b10);

        // Word read from the array in the same cycle it is written
        write_incr(c_BASE + 40'h40, 8'd0, 8'h0D, 8'hD0, 8'h00);
        aw_issue(c_BASE + 40'h40, 8'd0, c_INCR, 8'h0E);
        ar_issue(c_BASE + 40'h40, 8'd0, c_INCR, 8'h0F);
        @(negedge clk);
        w_beat(rep(8'hE0), 16'hFFFF, 1'b1);
        r_collect(1, 0);
        check("same_cycle_old_data", rd_data[0], rep(8'hD0));
        b_collect(bresp, bid);
        check("same_cycle_bresp", bresp, 2'b00);
        ar_issue(c_BASE + 40'h40, 8'd0, c_INCR, 8'h10);
        r_collect(1, 0);
        check("same_cycle_new_data", rd_data[0], rep(8'hE0));

        // Reset in the middle of a read burst
        ar_issue(c_BASE, 8'd7, c_INCR, 8'h11);
        g = 0;
        while (!r_valid && g < 50) begin @(negedge clk); g++; end
        check("rst_rd_valid_seen", r_valid, 1'b1);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_rd_abort", {r_valid, ar_ready, r_last}, 3'b010);
        check("rst_rd_data", r_data, '0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_no_beats", {r_valid, ar_ready}, 2'b01);

        // Reset in the middle of a write burst keeps the partial write
        aw_issue(c_BASE + 40'hC0, 8'd3, c_INCR, 8'h12);
        w_beat(rep(8'h99), 16'hFFFF, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wr_abort", {w_ready, aw_ready, b_valid}, 3'b010);
        reset = 1'b0;
        @(negedge clk);
        ar_issue(c_BASE + 40'hC0, 8'd0, c_INCR, 8'h13);
        r_collect(1, 0);
        check("rst_wr_partial_kept", rd_data[0], rep(8'h99));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
